// File: rtl/memory_pkg.sv
// Shared types for the MEM stage: pipeline bundles, funct3 codes and FSM states.
package memory_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        RegWrite;
    logic        MemToReg;
    logic        MemRead;
    logic        MemWrite;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemToReg;
  } mem_wb_t;

  typedef enum logic {IDLE, WAIT} mem_state_e;

endpackage

// File: rtl/memory_stage_lsu_align.sv
// Byte-lane steering: store enables/replicated data, load extract/extend, alignment check.
module lsu_align
  import memory_pkg::*;
(
  input  logic [1:0]  addr_lsb,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = 8'(rdata >> {addr_lsb, 3'b000});
    half_sel   = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
    be         = 4'hF;
    wdata      = rs2;
    load_data  = rdata;
    misaligned = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lsb;
          wdata = {4{rs2[7:0]}};
        end
        F3_SH: begin
          be         = 4'b0011 << addr_lsb;
          wdata      = {2{rs2[15:0]}};
          misaligned = addr_lsb[0];
        end
        F3_SW:   misaligned = |addr_lsb;
        default: misaligned = |addr_lsb;
      endcase
    end else begin
      // unknown load widths fall back to a full word
      case (funct3)
        F3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
        F3_LBU: load_data = {24'h0, byte_sel};
        F3_LH: begin
          load_data  = {{16{half_sel[15]}}, half_sel};
          misaligned = addr_lsb[0];
        end
        F3_LHU: begin
          load_data  = {16'h0, half_sel};
          misaligned = addr_lsb[0];
        end
        F3_LW:   misaligned = |addr_lsb;
        default: misaligned = |addr_lsb;
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: drives the data-memory handshake, waits for load data, registers mem_wb.
module memory_stage
  import memory_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_t           ex_mem,
  output mem_wb_t           mem_wb,
  output logic              stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rdata,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_wb_t          mem_wb_q, mem_wb_d;
  logic             misalign_err_q, misalign_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic        mem_op, is_store, misaligned, mis_drop, stall_raw;
  logic        req, complete, timeout;
  logic [31:0] load_data;

  assign mem_op   = ex_mem.valid & (ex_mem.MemRead | ex_mem.MemWrite);
  assign is_store = ex_mem.MemWrite;

  lsu_align u_align (
    .addr_lsb   (ex_mem.alu_result[1:0]),
    .funct3     (ex_mem.funct3),
    .is_store   (is_store),
    .rs2        (ex_mem.rs2_data),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          req = 1'b1;
          if (dmem_req_ready) begin
            if (is_store) complete = 1'b1;
            else          state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_rsp_valid) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mis_drop = (state_q == IDLE) && mem_op && misaligned;
  // timeout releases the stall so the abandoned load leaves ex_mem instead of retrying
  assign stall_raw = ((state_q == WAIT) || (mem_op && !misaligned)) && !complete && !timeout;

  always_comb begin
    mem_wb_d       = '0;
    misalign_err_d = mis_drop;
    timeout_err_d  = timeout;
    if (ex_mem.valid && !stall_raw && !timeout && !mis_drop) begin
      mem_wb_d.alu_result = ex_mem.alu_result;
      mem_wb_d.rd         = ex_mem.rd;
      mem_wb_d.RegWrite   = ex_mem.RegWrite;
      mem_wb_d.MemToReg   = ex_mem.MemToReg;
      mem_wb_d.mem_data   = (state_q == WAIT) ? load_data : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_wb_q       <= '0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_wb_q       <= mem_wb_d;
      misalign_err_q <= misalign_err_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign stall          = stall_raw & ~reset;
  assign dmem_req_valid = req & ~reset;
  assign dmem_addr      = {ex_mem.alu_result[ADDR_W-1:2], 2'b00};
  assign dmem_we        = is_store;
  assign mem_wb         = mem_wb_q;
  assign misalign_err   = misalign_err_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed + randomised bench for memory_stage against a byte-level reference memory model.
module tb_memory_stage;
  import memory_pkg::*;

  localparam int MAXW = 4;

  logic        clk, reset;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic        stall, dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        misalign_err, timeout_err;

  memory_stage #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .ex_mem(ex_mem), .mem_wb(mem_wb), .stall(stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int ready_lat = 0, rsp_lat = 1;
  logic rsp_never = 1'b0, force_rsp = 1'b0, chk_en = 1'b0;
  mem_wb_t exp_wb = '0;
  logic exp_mis = 1'b0, exp_to = 1'b0;
  logic cap_vld;
  logic [3:0] cap_be;
  logic [31:0] cap_wdata, cap_addr;

  logic [31:0] dev_mem [int];   // the memory device, written via be/wdata
  logic [7:0]  ref_mem [int];   // reference byte memory for the model

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int w);
    return 32'(w) ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
    return init_word(int'(a));
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a & ~3);
    return 8'(w >> (8 * (a & 3)));
  endfunction

  task automatic preload(input int a, input logic [31:0] w);
    dev_mem[a] = w;
    for (int k = 0; k < 4; k++) ref_mem[a + k] = 8'(w >> (8 * k));
  endtask

  function automatic int size_of(input logic [2:0] f3, input logic st);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  // what writeback must see once this instruction leaves MEM
  task automatic model(input ex_mem_t i, output mem_wb_t r, output logic mis, output logic to);
    int a, sz;
    longint v;
    r = '0; mis = 1'b0; to = 1'b0;
    if (!i.valid) return;
    a = int'(i.alu_result);
    if (i.MemWrite || i.MemRead) begin
      sz = size_of(i.funct3, i.MemWrite);
      if (a % sz != 0) begin mis = 1'b1; return; end
      if (i.MemWrite) begin
        for (int k = 0; k < sz; k++) ref_mem[a + k] = 8'(i.rs2_data >> (8 * k));
      end else if (rsp_never) begin
        to = 1'b1; return;
      end else begin
        v = 0;
        for (int k = 0; k < sz; k++) v += longint'(ref_rd(a + k)) << (8 * k);
        if ((i.funct3 == 3'd0 || i.funct3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
          v -= longint'(1) << (8 * sz);
        r.mem_data = 32'(v);
      end
    end
    r.alu_result = i.alu_result;
    r.rd         = i.rd;
    r.RegWrite   = i.RegWrite;
    r.MemToReg   = i.MemToReg;
  endtask

  function automatic ex_mem_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
    ex_mem_t e;
    e = '0;
    e.valid = 1'b1; e.alu_result = a; e.rs2_data = rs2; e.rd = rd; e.funct3 = f3;
    e.RegWrite = rw; e.MemToReg = mr; e.MemRead = mr; e.MemWrite = mw;
    return e;
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) chk("mem_wb", {mem_wb, misalign_err, timeout_err}, {exp_wb, exp_mis, exp_to});
    end
  endtask

  task automatic responder();
    int rcnt, pcnt;
    logic pend;
    logic [31:0] paddr;
    rcnt = 0; pcnt = 0; pend = 1'b0; paddr = '0;
    forever begin
      @(posedge clk); #2;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
      if (reset) begin
        pend = 1'b0; rcnt = 0;
      end else if (force_rsp) begin
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5A5A_5A5A;
      end else begin
        if (pend && dmem_req_valid) pend = 1'b0;  // previous load was abandoned
        if (pend) begin
          pcnt++;
          if (!rsp_never && pcnt >= rsp_lat) begin
            dmem_rsp_valid = 1'b1; dmem_rdata = dev_rd(paddr); pend = 1'b0;
          end
        end else if (dmem_req_valid) begin
          if (rcnt >= ready_lat) begin
            dmem_req_ready = 1'b1; rcnt = 0;
            if (dmem_we) begin
              for (int k = 0; k < 4; k++)
                if (dmem_be[k]) begin
                  logic [31:0] w;
                  w = dev_rd(dmem_addr);
                  w[8*k +: 8] = dmem_wdata[8*k +: 8];
                  dev_mem[int'(dmem_addr)] = w;
                end
            end else begin
              pend = 1'b1; pcnt = 0; paddr = dmem_addr;
            end
          end else rcnt++;
        end
      end
    end
  endtask

  task automatic issue(input ex_mem_t ins, output int stalls);
    mem_wb_t r;
    logic mis, to, st, first;
    ex_mem = ins; stalls = 0; first = 1'b1;
    model(ins, r, mis, to);
    forever begin
      @(negedge clk);
      st = stall;
      if (first) begin
        cap_vld = dmem_req_valid; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_addr = dmem_addr;
        first = 1'b0;
      end
      @(posedge clk); #1;
      if (!st) begin exp_wb = r; exp_mis = mis; exp_to = to; break; end
      exp_wb = '0; exp_mis = 1'b0; exp_to = 1'b0;
      stalls++;
      if (stalls > 50) begin chk("stall_bound", 1'b1, 1'b0); break; end
    end
  endtask

  task automatic idle(input int n);
    ex_mem = '0;
    repeat (n) begin
      @(posedge clk); #1;
      exp_wb = '0; exp_mis = 1'b0; exp_to = 1'b0;
    end
  endtask

  int st;
  logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    reset = 1'b1; ex_mem = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    fork
      compare_loop();
      responder();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {mem_wb, misalign_err, timeout_err, stall, dmem_req_valid}, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // LB / LBU sign vs zero extension
    ready_lat = 0; rsp_lat = 1;
    preload(32'h1000, 32'h80FF_FF7F);
    issue(mk(3'd0, 32'h1003, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0), st);
    chk("lb_stall", st, 1);
    ex_mem = '0; @(negedge clk);
    chk("lb_data", mem_wb.mem_data, 32'hFFFF_FF80);
    idle(1);
    issue(mk(3'd4, 32'h1003, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0), st);
    ex_mem = '0; @(negedge clk);
    chk("lbu_data", mem_wb.mem_data, 32'h0000_0080);
    idle(1);

    // SH upper half: lane enables, replication, word address, no stall
    issue(mk(3'd1, 32'h2002, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0, 1'b1), st);
    chk("sh_req", cap_vld, 1'b1);
    chk("sh_be", cap_be, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_addr", cap_addr, 32'h2000);
    chk("sh_stall", st, 0);
    issue(mk(3'd2, 32'h2000, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0), st);

    // LW with ready held low 3 cycles and response 2 cycles after accept
    ready_lat = 3; rsp_lat = 2;
    preload(32'h3004, 32'hCAFE_F00D);
    issue(mk(3'd2, 32'h3004, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0), st);
    chk("lw_stall5", st, 5);
    ex_mem = '0; @(negedge clk);
    chk("lw_data", {mem_wb.mem_data, mem_wb.rd, mem_wb.RegWrite}, {32'hCAFE_F00D, 5'd9, 1'b1});
    idle(2);

    // misaligned LW is dropped
    ready_lat = 0; rsp_lat = 1;
    issue(mk(3'd2, 32'h1002, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0), st);
    chk("mis_noreq", {cap_vld, 8'(st)}, {1'b0, 8'd0});
    ex_mem = '0; @(negedge clk);
    chk("mis_pulse", {misalign_err, mem_wb.RegWrite, mem_wb.rd}, {1'b1, 1'b0, 5'd0});
    idle(1);

    // load whose response never arrives
    rsp_never = 1'b1;
    issue(mk(3'd2, 32'h4000, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0), st);
    chk("to_stall", st, MAXW);
    ex_mem = '0; @(negedge clk);
    chk("to_pulse", {timeout_err, mem_wb.RegWrite}, {1'b1, 1'b0});
    idle(1);
    rsp_never = 1'b0;

    // reset while waiting for load data, then a stray response
    chk_en = 1'b0; rsp_lat = 10;
    ex_mem = mk(3'd2, 32'h5000, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_stall", stall, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; ex_mem = '0;
    #2;
    chk("rst_outs", {stall, dmem_req_valid, mem_wb.RegWrite}, 3'b000);
    @(negedge clk); reset = 1'b0; #1;
    chk("rst_idle", stall, 1'b0);
    @(posedge clk); #1; force_rsp = 1'b1;
    @(posedge clk); #1; force_rsp = 1'b0;
    @(negedge clk);
    chk("rst_no_wb", {mem_wb, timeout_err, misalign_err}, '0);
    exp_wb = '0; exp_mis = 1'b0; exp_to = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // back-to-back stores, loads and ALU ops with varying handshake latency
    for (int i = 0; i < 40; i++) begin
      int kind, sz, exp_st;
      logic [2:0] f3;
      logic [31:0] a;
      ex_mem_t e;
      kind = $urandom_range(0, 2);
      ready_lat = $urandom_range(0, 2);
      rsp_lat = $urandom_range(1, 3);
      if (kind == 2) begin
        e = mk(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0, 1'b0);
        exp_st = 0;
      end else begin
        f3 = (kind == 0) ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
        sz = size_of(f3, kind == 0);
        a = 32'h6000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 4 / sz - 1) * sz);
        e = mk(f3, a, $urandom, 5'($urandom_range(1, 31)), kind == 1, kind == 1, kind == 0);
        exp_st = (kind == 0) ? ready_lat : ready_lat + rsp_lat;
      end
      issue(e, st);
      chk("rand_stall", st, exp_st);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
